spi_burst_ctrl: RTL

Transaction sequencer that sits directly upstream of the byte-level SPI master core.
- Buffers outgoing bytes in a TX FIFO and accepts burst commands of 1–16 bytes.
- Frames each burst with an active-low slave select, with programmable setup and hold gaps.
- Issues one start pulse per byte to the core and captures each received byte into an RX FIFO for the processor.

---
 rtl/spi_pkg.sv | 18 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/spi_burst_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI burst controller slice.
//   burst_state_t : sequencer states
//   SPI_BYTE_W    : width of one SPI byte
//   BURST_LEN_W   : width of the burst length field (length minus one)
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    LOAD      = 3'd2,
    WAIT_DONE = 3'd3,
    HOLD      = 3'd4
  } burst_state_t;

  localparam int SPI_BYTE_W  = 8;
  localparam int BURST_LEN_W = 4;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push/wdata : write strobe and data; ignored while full
//   pop        : read strobe; ignored while empty
//   rdata      : head entry, visible without a pop
//   full/empty : occupancy flags
// Push and pop together on a non-empty FIFO keep the count; on an empty
// FIFO only the push takes effect.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of a byte-level SPI master core.
//   cmd_valid/cmd_ready/cmd_len : burst command (length minus one)
//   tx_wr/tx_wdata/tx_full      : TX byte buffer write side
//   rx_rd/rx_rdata/rx_empty     : RX byte buffer read side (FWFT)
//   ss_n, busy                  : slave select (active low), not-idle flag
//   spi_start/spi_din           : one-cycle start pulse and byte to the core
//   spi_dout/spi_ready/spi_done_tick : core status and received byte
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_valid in any other cycle has no effect.
// tx_wr and rx_rd are single-cycle strobes qualified by tx_full/rx_empty.
module spi_burst_ctrl
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int SETUP_CYC  = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [BURST_LEN_W-1:0] cmd_len,
  input  logic                   tx_wr,
  input  logic [SPI_BYTE_W-1:0]  tx_wdata,
  output logic                   tx_full,
  input  logic                   rx_rd,
  output logic [SPI_BYTE_W-1:0]  rx_rdata,
  output logic                   rx_empty,
  output logic                   ss_n,
  output logic                   busy,
  output logic                   spi_start,
  output logic [SPI_BYTE_W-1:0]  spi_din,
  input  logic [SPI_BYTE_W-1:0]  spi_dout,
  input  logic                   spi_ready,
  input  logic                   spi_done_tick
);

  // spi_start is registered, so the LOAD decision cycle is itself the last
  // cycle of the setup gap. SETUP therefore covers the first SETUP_CYC-1
  // cycles and is skipped entirely when SETUP_CYC is 1.
  localparam logic [7:0] SETUP_LAST = 8'((SETUP_CYC > 1) ? SETUP_CYC - 2 : 0);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);

  burst_state_t           state, state_nx;
  logic [7:0]             gap_cnt, gap_cnt_nx;
  logic [BURST_LEN_W-1:0] remaining, remaining_nx;
  logic                   launch;
  logic                   rx_push;
  logic                   tx_empty;
  logic                   rx_full;
  logic [SPI_BYTE_W-1:0]  tx_head;

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .pop   (launch),
    .wdata (tx_wdata),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_rd),
    .wdata (spi_dout),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    state_nx     = state;
    gap_cnt_nx   = gap_cnt;
    remaining_nx = remaining;
    launch       = 1'b0;
    rx_push      = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          remaining_nx = cmd_len;
          gap_cnt_nx   = '0;
          state_nx     = (SETUP_CYC == 1) ? LOAD : SETUP;
        end
      end
      SETUP: begin
        if (gap_cnt == SETUP_LAST) state_nx = LOAD;
        else                       gap_cnt_nx = gap_cnt + 1'b1;
      end
      LOAD: begin
        // RX space is checked up front so the received byte always fits.
        if (spi_ready && !tx_empty && !rx_full) begin
          launch   = 1'b1;
          state_nx = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (spi_done_tick) begin
          rx_push = 1'b1;
          if (remaining == '0) begin
            gap_cnt_nx = '0;
            state_nx   = HOLD;
          end else begin
            remaining_nx = remaining - 1'b1;
            state_nx     = LOAD;
          end
        end
      end
      HOLD: begin
        if (gap_cnt == HOLD_LAST) state_nx = IDLE;
        else                      gap_cnt_nx = gap_cnt + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      remaining <= '0;
      spi_start <= 1'b0;
      spi_din   <= '0;
    end else begin
      state     <= state_nx;
      gap_cnt   <= gap_cnt_nx;
      remaining <= remaining_nx;
      spi_start <= launch;
      if (launch) spi_din <= tx_head;
    end
  end

  // Decoded straight from the state register so reset releases ss_n at once.
  assign ss_n      = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);

endmodule
